// File: rtl/nx_packetiser_pkg.sv
// Shared types and width helpers for the AXI4-stream packetiser.
// Holds the decision FSM state type and counter-width derivations.
package nx_packetiser_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    HOLD,
    PRESENT
  } packetiser_state_t;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int DEF_MAX_BEATS = 64;
  localparam int DEF_TIMEOUT   = 1024;
  localparam int DEF_BEAT_W    = cnt_width(DEF_MAX_BEATS);
  localparam int DEF_TIMER_W   = cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/nx_packetiser_fifo.sv
// Single-clock FIFO of {tlast, tdata} beats for the packetiser input.
// Ports: i_push/i_wdata write, i_pop/o_rdata read (show-ahead),
// o_full/o_empty flags and a registered occupancy o_count.
module nx_packetiser_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/nx_axi4s_packetiser.sv
// Re-frames a sparse AXI4-stream into packets for host DMA. TLAST is
// forced on upstream TLAST, after MAX_BEATS beats, or after TIMEOUT
// idle cycles. Ports: i_ib_* inbound stream, o_ob_*/i_ob_axi4s_tready
// outbound stream, o_idle when fully drained. Optional stats counters
// o_stat_packets/o_stat_timeouts exist when NX_PACKETISER_STATS_EN is
// defined.
module nx_axi4s_packetiser
  import nx_packetiser_pkg::*;
#(
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int DEPTH           = 8,
  parameter int MAX_BEATS       = 64,
  parameter int TIMEOUT         = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [AXI4_DATA_WIDTH-1:0] i_ib_axi4s_tdata,
  input  logic                       i_ib_axi4s_tlast,
  input  logic                       i_ib_axi4s_tvalid,
  output logic                       o_ib_axi4s_tready,
  output logic [AXI4_DATA_WIDTH-1:0] o_ob_axi4s_tdata,
  output logic                       o_ob_axi4s_tlast,
  output logic                       o_ob_axi4s_tvalid,
  input  logic                       i_ob_axi4s_tready,
  output logic                       o_idle
`ifdef NX_PACKETISER_STATS_EN
  ,
  output logic [31:0]                o_stat_packets,
  output logic [31:0]                o_stat_timeouts
`endif
);

  localparam int DW    = AXI4_DATA_WIDTH;
  localparam int CNT_W = cnt_width(MAX_BEATS);
  localparam int TMR_W = cnt_width(TIMEOUT);
  localparam int FCW   = $clog2(DEPTH + 1);

  packetiser_state_t r_state;
  packetiser_state_t w_state_nxt;
  logic [DW-1:0]     r_data;
  logic [DW-1:0]     w_data_nxt;
  logic              r_last;
  logic              w_last_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [TMR_W-1:0]  r_timer;
  logic [TMR_W-1:0]  w_timer_nxt;

  logic [DW:0]       w_fifo_rdata;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [FCW-1:0]    w_fifo_count;
  logic              w_push;
  logic              w_pop;
  logic              w_hs;
  logic              w_timeout_evt;
  logic [CNT_W-1:0]  w_base_cnt;
  logic [CNT_W-1:0]  w_pop_cnt;
  logic              w_pop_last;
  logic              w_more;

  assign w_push = i_ib_axi4s_tvalid & ~w_fifo_full;

  nx_packetiser_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata ({i_ib_axi4s_tlast, i_ib_axi4s_tdata}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_hs = (r_state == PRESENT) & i_ob_axi4s_tready;

  // A packet closing on this handshake restarts the count for the
  // beat popped in the same cycle.
  assign w_base_cnt = (w_hs & r_last) ? '0 : r_cnt;
  assign w_pop_cnt  = w_base_cnt + CNT_W'(1);
  assign w_pop_last = w_fifo_rdata[DW] |
                      (w_pop_cnt == CNT_W'(MAX_BEATS));

  // Occupancy after popping one beat, counting a same-cycle push.
  assign w_more = (w_fifo_count > FCW'(1)) | w_push;

  always_comb begin
    w_state_nxt   = r_state;
    w_data_nxt    = r_data;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_timer_nxt   = r_timer;
    w_pop         = 1'b0;
    w_timeout_evt = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (!w_fifo_empty) begin
          w_pop      = 1'b1;
          w_data_nxt = w_fifo_rdata[DW-1:0];
          w_cnt_nxt  = w_pop_cnt;
          if (w_pop_last) begin
            w_state_nxt = PRESENT;
            w_last_nxt  = 1'b1;
          end else begin
            w_state_nxt = HOLD;
            w_last_nxt  = 1'b0;
            w_timer_nxt = '0;
          end
        end
      end
      HOLD: begin
        if (!w_fifo_empty) begin
          w_state_nxt = PRESENT;
          w_last_nxt  = 1'b0;
        end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
          w_state_nxt   = PRESENT;
          w_last_nxt    = 1'b1;
          w_timeout_evt = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      PRESENT: begin
        if (w_hs) begin
          w_cnt_nxt = w_base_cnt;
          if (!w_fifo_empty) begin
            w_pop      = 1'b1;
            w_data_nxt = w_fifo_rdata[DW-1:0];
            w_cnt_nxt  = w_pop_cnt;
            if (w_pop_last) begin
              w_last_nxt = 1'b1;
            end else if (w_more) begin
              w_last_nxt = 1'b0;
            end else begin
              w_state_nxt = HOLD;
              w_last_nxt  = 1'b0;
              w_timer_nxt = '0;
            end
          end else begin
            w_state_nxt = EMPTY;
          end
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  assign o_ib_axi4s_tready = ~w_fifo_full;
  assign o_ob_axi4s_tdata  = r_data;
  assign o_ob_axi4s_tlast  = r_last;
  assign o_ob_axi4s_tvalid = (r_state == PRESENT);
  assign o_idle = w_fifo_empty & (r_state == EMPTY);

`ifdef NX_PACKETISER_STATS_EN
  logic [31:0] r_stat_packets;
  logic [31:0] r_stat_timeouts;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stat_packets  <= '0;
      r_stat_timeouts <= '0;
    end else begin
      if (w_hs && r_last && !(&r_stat_packets)) begin
        r_stat_packets <= r_stat_packets + 32'd1;
      end
      if (w_timeout_evt && !(&r_stat_timeouts)) begin
        r_stat_timeouts <= r_stat_timeouts + 32'd1;
      end
    end
  end

  assign o_stat_packets  = r_stat_packets;
  assign o_stat_timeouts = r_stat_timeouts;
`endif

endmodule

// File: tb/tb_nx_axi4s_packetiser.sv
// Directed and randomised checks of nx_axi4s_packetiser.
// Instance A: MAX_BEATS=64, instance B: MAX_BEATS=4; both TIMEOUT=16.
module tb_nx_axi4s_packetiser;

  localparam int W  = 128;
  localparam int NR = 1000;

  typedef logic [W+1:0] val_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         in_valid;
  logic         out_ready;

  logic         a_in_rdy, b_in_rdy;
  logic [W-1:0] a_data, b_data;
  logic         a_last, b_last;
  logic         a_vld, b_vld;
  logic         a_idle, b_idle;
`ifdef NX_PACKETISER_STATS_EN
  logic [31:0]  a_pk, a_to, b_pk, b_to;
`endif

  logic         w_in_ready;
  logic [W-1:0] w_data;
  logic         w_last;
  logic         w_vld;
  logic         w_idle;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_acc = 0;
  int acc_cyc = 0;
  int n_out = 0;
  int pkt   = 0;
  int sb_max = 4;
  logic sb_on = 1'b0;
  logic hold_v = 1'b0;
  logic [W:0] hold_beat;
  logic [W:0] acc_q [$];
  logic [W:0] obs_q [$];
  int         obs_cyc [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  nx_axi4s_packetiser #(
    .AXI4_DATA_WIDTH (W),
    .DEPTH           (8),
    .MAX_BEATS       (64),
    .TIMEOUT         (16)
  ) u_dut_a (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_ib_axi4s_tdata  (in_data),
    .i_ib_axi4s_tlast  (in_last),
    .i_ib_axi4s_tvalid (in_valid & ~sel),
    .o_ib_axi4s_tready (a_in_rdy),
    .o_ob_axi4s_tdata  (a_data),
    .o_ob_axi4s_tlast  (a_last),
    .o_ob_axi4s_tvalid (a_vld),
    .i_ob_axi4s_tready (out_ready & ~sel),
    .o_idle            (a_idle)
`ifdef NX_PACKETISER_STATS_EN
    ,
    .o_stat_packets    (a_pk),
    .o_stat_timeouts   (a_to)
`endif
  );

  nx_axi4s_packetiser #(
    .AXI4_DATA_WIDTH (W),
    .DEPTH           (8),
    .MAX_BEATS       (4),
    .TIMEOUT         (16)
  ) u_dut_b (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_ib_axi4s_tdata  (in_data),
    .i_ib_axi4s_tlast  (in_last),
    .i_ib_axi4s_tvalid (in_valid & sel),
    .o_ib_axi4s_tready (b_in_rdy),
    .o_ob_axi4s_tdata  (b_data),
    .o_ob_axi4s_tlast  (b_last),
    .o_ob_axi4s_tvalid (b_vld),
    .i_ob_axi4s_tready (out_ready & sel),
    .o_idle            (b_idle)
`ifdef NX_PACKETISER_STATS_EN
    ,
    .o_stat_packets    (b_pk),
    .o_stat_timeouts   (b_to)
`endif
  );

  assign w_in_ready = sel ? b_in_rdy : a_in_rdy;
  assign w_data     = sel ? b_data : a_data;
  assign w_last     = sel ? b_last : a_last;
  assign w_vld      = sel ? b_vld : a_vld;
  assign w_idle     = sel ? b_idle : a_idle;

  task automatic check(input string tag, input val_t got,
                       input val_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (in_valid && w_in_ready) begin
        acc_q.push_back({in_last, in_data});
        acc_cyc = cyc;
        n_acc++;
      end
      if (hold_v) begin
        check("out_stable", {w_vld, w_last, w_data},
              {1'b1, hold_beat});
      end
      hold_v = w_vld && !out_ready;
      hold_beat = {w_last, w_data};
      if (w_vld && out_ready) begin
        obs_q.push_back({w_last, w_data});
        obs_cyc.push_back(cyc);
        if (sb_on) begin
          if (acc_q.size() == 0) begin
            check("sb_underflow", val_t'(0), val_t'(1));
          end else begin
            logic [W:0] e;
            logic el;
            e  = acc_q.pop_front();
            el = e[W] | (pkt == sb_max - 1);
            check("sb_data", val_t'(w_data), val_t'(e[W-1:0]));
            check("sb_last", val_t'(w_last), val_t'(el));
            pkt = el ? 0 : pkt + 1;
            n_out++;
          end
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic l);
    int n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!w_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_budget", val_t'(0), val_t'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_obs(input int k, input int budget);
    int n = 0;
    while (obs_q.size() < k && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (obs_q.size() < k) begin
      check("wait_obs", val_t'(obs_q.size()), val_t'(k));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    int n0;
    logic took;
    int sent;
    int gap;
    int cn;

    rst = 1'b1;
    sel = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_out", val_t'({a_vld, a_last, a_data}), val_t'(0));
    check("rst_b_out", val_t'({b_vld, b_last, b_data}), val_t'(0));
    check("rst_idle", val_t'({a_idle, b_idle}), val_t'(2'b11));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rdy_post_rst", val_t'({a_in_rdy, b_in_rdy}),
          val_t'(2'b11));
    idle(1);

    // Single beat times out after 16 HOLD cycles.
    clr();
    send(W'(128'hA5), 1'b0);
    t0 = acc_cyc;
    wait_obs(1, 40);
    if (obs_q.size() >= 1) begin
      check("t1_beat", val_t'(obs_q[0]), val_t'({1'b1, W'(128'hA5)}));
      check("t1_latency", val_t'(obs_cyc[0] - t0), val_t'(18));
    end
    @(negedge clk);
`ifdef NX_PACKETISER_STATS_EN
    check("t1_stat_to", val_t'(a_to), val_t'(1));
    check("t1_stat_pk", val_t'(a_pk), val_t'(1));
`endif
    idle(2);

    // Five back-to-back beats, upstream last on the fifth.
    clr();
    for (int i = 0; i < 5; i++) send(W'(16'h10 + i), (i == 4));
    wait_obs(5, 40);
    if (obs_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("t2_beat%0d", i), val_t'(obs_q[i]),
              val_t'({(i == 4), W'(16'h10 + i)}));
        check($sformatf("t2_gap%0d", i),
              val_t'(obs_cyc[i] - obs_cyc[0]), val_t'(i));
      end
    end
    @(negedge clk);
`ifdef NX_PACKETISER_STATS_EN
    check("t2_stat_pk", val_t'(a_pk), val_t'(2));
    check("t2_stat_to", val_t'(a_to), val_t'(1));
`endif
    idle(2);

    // MAX_BEATS=4: ten beats, forced last on 4, 8, and 10 by timeout.
    sel = 1'b1;
    idle(1);
    clr();
    for (int i = 0; i < 10; i++) send(W'(16'h20 + i), 1'b0);
    wait_obs(10, 100);
    if (obs_q.size() >= 10) begin
      for (int i = 0; i < 10; i++) begin
        check($sformatf("t3_beat%0d", i), val_t'(obs_q[i]),
              val_t'({(i == 3 || i == 7 || i == 9), W'(16'h20 + i)}));
      end
      check("t3_stream", val_t'(obs_cyc[8] - obs_cyc[0]), val_t'(8));
      check("t3_timeout", val_t'(obs_cyc[9] - obs_cyc[8]), val_t'(17));
    end
    idle(2);

    // Fill under back-pressure: FIFO plus holding register.
    sel = 1'b0;
    idle(1);
    clr();
    out_ready = 1'b0;
    n0 = n_acc;
    in_valid = 1'b1;
    in_last = 1'b0;
    in_data = W'(16'h40);
    repeat (20) begin
      @(negedge clk);
      took = w_in_ready;
      @(posedge clk);
      #1;
      if (took) in_data = in_data + W'(1);
    end
    in_valid = 1'b0;
    check("t4_accepted", val_t'(n_acc - n0), val_t'(9));
    check("t4_rdy_low", val_t'(w_in_ready), val_t'(0));
    out_ready = 1'b1;
    wait_obs(9, 60);
    if (obs_q.size() >= 9) begin
      for (int i = 0; i < 9; i++) begin
        check($sformatf("t4_beat%0d", i), val_t'(obs_q[i]),
              val_t'({(i == 8), W'(16'h40 + i)}));
      end
    end
    @(negedge clk);
    #1;
    check("t4_idle", val_t'(w_idle), val_t'(1));

    // Reset mid-packet discards buffered beats and the beat count.
    sel = 1'b1;
    idle(1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(W'(16'h50 + i), 1'b0);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_vld", val_t'(w_vld), val_t'(0));
    check("t5_rst_idle", val_t'(w_idle), val_t'(1));
`ifdef NX_PACKETISER_STATS_EN
    check("t5_rst_stats", val_t'({b_pk, b_to}), val_t'(0));
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    clr();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(W'(16'h60 + i), 1'b0);
    wait_obs(4, 60);
    if (obs_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t5_beat%0d", i), val_t'(obs_q[i]),
              val_t'({(i == 3), W'(16'h60 + i)}));
      end
    end
    idle(20);
    check("t5_no_stale", val_t'(obs_q.size()), val_t'(4));

    // Randomly throttled stream against the scoreboard.
    acc_q.delete();
    pkt = 0;
    n_out = 0;
    sb_max = 4;
    sb_on = 1'b1;
    sent = 0;
    gap = 0;
    took = 1'b0;
    cn = 0;
    in_valid = 1'b0;
    while ((sent < NR || (in_valid && !took)) && cn < 20000) begin
      if (!in_valid || took) begin
        if (sent < NR && ($urandom_range(1, 0) == 1 || gap >= 3)) begin
          in_valid = 1'b1;
          in_data = {$urandom, $urandom, $urandom, $urandom};
          in_last = (sent == NR - 1) || ($urandom_range(7, 0) == 0);
          sent++;
          gap = 0;
        end else begin
          in_valid = 1'b0;
          gap++;
        end
      end
      out_ready = ($urandom_range(3, 0) != 0);
      @(negedge clk);
      took = in_valid && w_in_ready;
      @(posedge clk);
      #1;
      cn++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cn = 0;
    while (n_out < NR && cn < 500) begin
      @(negedge clk);
      #1;
      cn++;
    end
    check("t6_count", val_t'(n_out), val_t'(NR));
    sb_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
